// File: rtl/frame_window_fetch.sv
`default_nettype none
// ============================================================================
// Module   : frame_window_fetch
// Purpose  : Accepts a frame descriptor (start / exclusive end address),
//            fetches FRAME_SIZE samples from sample memory in address order,
//            multiplies each by its window coefficient (Q0.COEFW, floor) and
//            streams the windowed samples out through a 2-entry buffer with
//            valid/ready flow control.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   i_frame_start/_end       descriptor: first address, exclusive bound
//   i_valid / o_ready        descriptor handshake (o_ready only in IDLE)
//   o_mem_rd/o_mem_addr      sample memory read; i_mem_data one cycle later
//   o_coef_idx / i_coef      window ROM index with the read; data one cycle later
//   o_sample/o_valid/i_ready windowed sample stream, o_last on final sample
//   o_frame_done             pulse on the handshake of the o_last sample
//   o_err                    pulse when a malformed descriptor is dropped
//   o_ovf                    sticky: descriptor presented while busy
// ============================================================================
module frame_window_fetch #(
  parameter int ADDRW      = 32,
  parameter int DATAW      = 16,
  parameter int COEFW      = 16,
  parameter int FRAME_SIZE = 4,
  localparam int c_idxw    = (FRAME_SIZE > 1) ? $clog2(FRAME_SIZE) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDRW-1:0]  i_frame_start,
  input  logic [ADDRW-1:0]  i_frame_end,
  input  logic              i_valid,
  output logic              o_ready,
  output logic              o_mem_rd,
  output logic [ADDRW-1:0]  o_mem_addr,
  input  logic [DATAW-1:0]  i_mem_data,
  output logic [c_idxw-1:0] o_coef_idx,
  input  logic [COEFW-1:0]  i_coef,
  output logic [DATAW-1:0]  o_sample,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_last,
  output logic              o_frame_done,
  output logic              o_err,
  output logic              o_ovf
);

  localparam int c_prodw = DATAW + COEFW + 1;

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_fetch = 2'd1;
  localparam logic [1:0] c_st_drain = 2'd2;

  localparam logic [c_idxw-1:0] c_last_idx  = c_idxw'(FRAME_SIZE - 1);
  localparam logic [ADDRW-1:0]  c_frame_len = ADDRW'(FRAME_SIZE);

  logic [1:0]        r_state;
  logic [ADDRW-1:0]  r_start;
  logic [c_idxw-1:0] r_idx;
  logic              r_in_flight;
  logic              r_in_flight_last;
  logic [DATAW-1:0]  r_buf_data [2];
  logic [1:0]        r_buf_last;
  logic              r_rd_ptr;
  logic              r_wr_ptr;
  logic [1:0]        r_count;
  logic              r_err;
  logic              r_ovf;

  logic                      w_accept;
  logic                      w_len_ok;
  logic                      w_pop;
  logic [2:0]                w_occ;
  logic                      w_issue;
  logic signed [c_prodw-1:0] w_data_ext;
  logic signed [c_prodw-1:0] w_coef_ext;
  logic signed [c_prodw-1:0] w_prod;
  logic [DATAW-1:0]          w_result;
  logic                      w_unused_prod_bits;

  assign w_accept = i_valid && (r_state == c_st_idle);
  // Modular difference, so a frame straddling the top of the address space is legal.
  assign w_len_ok = ((i_frame_end - i_frame_start) == c_frame_len);
  assign w_pop    = o_valid && i_ready;

  // Slots the buffer would still have committed after this cycle; a pop this
  // cycle frees a slot immediately, which is what allows one sample per cycle.
  assign w_occ   = {1'b0, r_count} + {2'b00, r_in_flight} - {2'b00, w_pop};
  assign w_issue = (r_state == c_st_fetch) && (w_occ < 3'd2);

  // Signed sample times unsigned coefficient. Taking bits [COEFW +: DATAW] of
  // the full product is an arithmetic shift right, i.e. floor division.
  assign w_data_ext         = c_prodw'($signed(i_mem_data));
  assign w_coef_ext         = $signed(c_prodw'(i_coef));
  assign w_prod             = w_data_ext * w_coef_ext;
  assign w_result           = w_prod[COEFW +: DATAW];
  assign w_unused_prod_bits = ^{w_prod[COEFW-1:0], w_prod[c_prodw-1]};

  assign o_ready      = (r_state == c_st_idle);
  assign o_mem_rd     = w_issue;
  assign o_mem_addr   = r_start + ADDRW'(r_idx);
  assign o_coef_idx   = r_idx;
  assign o_valid      = (r_count != 2'd0);
  assign o_sample     = r_buf_data[r_rd_ptr];
  assign o_last       = o_valid && r_buf_last[r_rd_ptr];
  assign o_frame_done = w_pop && o_last;
  assign o_err        = r_err;
  assign o_ovf        = r_ovf;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state          <= c_st_idle;
      r_start          <= '0;
      r_idx            <= '0;
      r_in_flight      <= 1'b0;
      r_in_flight_last <= 1'b0;
      r_buf_data[0]    <= '0;
      r_buf_data[1]    <= '0;
      r_buf_last       <= '0;
      r_rd_ptr         <= 1'b0;
      r_wr_ptr         <= 1'b0;
      r_count          <= '0;
      r_err            <= 1'b0;
      r_ovf            <= 1'b0;
    end else begin
      r_err <= w_accept && !w_len_ok;
      if (i_valid && !o_ready) begin
        r_ovf <= 1'b1;
      end

      case (r_state)
        c_st_idle: begin
          if (w_accept && w_len_ok) begin
            r_start <= i_frame_start;
            r_idx   <= '0;
            r_state <= c_st_fetch;
          end
        end
        c_st_fetch: begin
          if (w_issue) begin
            if (r_idx == c_last_idx) begin
              r_state <= c_st_drain;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        c_st_drain: begin
          if (o_frame_done) begin
            r_state <= c_st_idle;
          end
        end
        default: r_state <= c_st_idle;
      endcase

      // Memory and ROM answer one cycle after the read; capture then.
      r_in_flight      <= w_issue;
      r_in_flight_last <= w_issue && (r_idx == c_last_idx);
      if (r_in_flight) begin
        r_buf_data[r_wr_ptr] <= w_result;
        r_buf_last[r_wr_ptr] <= r_in_flight_last;
        r_wr_ptr             <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, r_in_flight} - {1'b0, w_pop};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_frame_window_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_window_fetch
// Purpose  : Directed, table-driven bench for frame_window_fetch with a
//            sample-memory / window-ROM responder and an output monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_frame_window_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_frame_start;
  logic [31:0] i_frame_end;
  logic        i_valid;
  logic        o_ready;
  logic        o_mem_rd;
  logic [31:0] o_mem_addr;
  logic [15:0] i_mem_data;
  logic [1:0]  o_coef_idx;
  logic [15:0] i_coef;
  logic [15:0] o_sample;
  logic        o_valid;
  logic        i_ready;
  logic        o_last;
  logic        o_frame_done;
  logic        o_err;
  logic        o_ovf;

  frame_window_fetch #(
    .ADDRW(32), .DATAW(16), .COEFW(16), .FRAME_SIZE(4)
  ) dut (
    .clk(clk), .rst(rst),
    .i_frame_start(i_frame_start), .i_frame_end(i_frame_end),
    .i_valid(i_valid), .o_ready(o_ready),
    .o_mem_rd(o_mem_rd), .o_mem_addr(o_mem_addr), .i_mem_data(i_mem_data),
    .o_coef_idx(o_coef_idx), .i_coef(i_coef),
    .o_sample(o_sample), .o_valid(o_valid), .i_ready(i_ready),
    .o_last(o_last), .o_frame_done(o_frame_done),
    .o_err(o_err), .o_ovf(o_ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0]        start;
    logic [31:0]        fend;
    logic signed [15:0] data;
    logic [15:0]        coef;
    logic               exp_err;
    logic signed [15:0] exp_sample;
  } vec_t;

  vec_t vecs[10];

  // responder configuration
  logic               addr_mode = 1'b0;
  logic signed [15:0] cur_data  = 16'sd0;
  logic [15:0]        cur_coef  = 16'h0;

  // monitor records
  logic [31:0]        rd_addr_q[$];
  logic [1:0]         rd_idx_q[$];
  int                 rd_cyc_q[$];
  logic signed [15:0] out_q[$];
  logic               out_last_q[$];
  logic               out_done_q[$];
  int                 out_cyc_q[$];
  int                 err_cnt = 0;
  int                 err_cyc = -1;
  int                 done_cnt = 0;
  int                 nr_cnt = 0;
  int                 acc_cyc = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Memory + ROM: answer exactly one cycle after a read; junk otherwise.
  initial begin : mem_model
    logic        m_rd;
    logic [31:0] m_addr;
    logic [15:0] tmp;
    i_mem_data = 16'h0;
    i_coef     = 16'h0;
    forever begin
      @(negedge clk);
      m_rd   = o_mem_rd;
      m_addr = o_mem_addr;
      @(posedge clk);
      #1;
      if (m_rd) begin
        tmp        = 16'(m_addr[7:0]) + 16'd1;
        i_mem_data = addr_mode ? (tmp << 4) : cur_data;
        i_coef     = cur_coef;
      end else begin
        i_mem_data = 16'h5A5A;
        i_coef     = 16'hA5A5;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      if (o_mem_rd) begin
        rd_addr_q.push_back(o_mem_addr);
        rd_idx_q.push_back(o_coef_idx);
        rd_cyc_q.push_back(cyc);
      end
      if (o_valid && i_ready) begin
        out_q.push_back(o_sample);
        out_last_q.push_back(o_last);
        out_done_q.push_back(o_frame_done);
        out_cyc_q.push_back(cyc);
      end
      if (o_frame_done) done_cnt++;
      if (o_err) begin
        err_cnt++;
        err_cyc = cyc;
      end
      if (!o_ready) nr_cnt++;
    end
  end

  task automatic clear_mon();
    rd_addr_q.delete(); rd_idx_q.delete(); rd_cyc_q.delete();
    out_q.delete(); out_last_q.delete(); out_done_q.delete(); out_cyc_q.delete();
    err_cnt = 0; err_cyc = -1; done_cnt = 0; nr_cnt = 0;
  endtask

  task automatic send_desc(input logic [31:0] s, input logic [31:0] e);
    i_frame_start = s;
    i_frame_end   = e;
    i_valid       = 1'b1;
    acc_cyc       = cyc;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic wait_out(input int n, input int budget, input string name);
    int k = 0;
    while (out_q.size() < n && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk({name, "_outputs_in_time"}, longint'(out_q.size() >= n), 1);
  endtask

  task automatic chk_reset_outs(input string t);
    chk({t, "_mem_rd"}, o_mem_rd, 0);
    chk({t, "_valid"}, o_valid, 0);
    chk({t, "_last"}, o_last, 0);
    chk({t, "_frame_done"}, o_frame_done, 0);
    chk({t, "_err"}, o_err, 0);
    chk({t, "_ovf"}, o_ovf, 0);
    chk({t, "_mem_addr"}, o_mem_addr, 0);
    chk({t, "_coef_idx"}, o_coef_idx, 0);
    chk({t, "_sample"}, o_sample, 0);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    logic [31:0] ea;
    clear_mon();
    addr_mode = 1'b0;
    cur_data  = v.data;
    cur_coef  = v.coef;
    i_ready   = 1'b1;
    send_desc(v.start, v.fend);
    if (v.exp_err) begin
      repeat (5) @(posedge clk);
      #1;
      chk({name, "_err_pulses"}, err_cnt, 1);
      chk({name, "_err_cycle"}, err_cyc, acc_cyc + 1);
      chk({name, "_no_reads"}, rd_addr_q.size(), 0);
      chk({name, "_ready_low_cycles"}, nr_cnt, 0);
      chk({name, "_no_outputs"}, out_q.size(), 0);
    end else begin
      wait_out(4, 40, name);
      repeat (2) @(posedge clk);
      #1;
      chk({name, "_n_reads"}, rd_addr_q.size(), 4);
      chk({name, "_n_outputs"}, out_q.size(), 4);
      chk({name, "_done_pulses"}, done_cnt, 1);
      chk({name, "_err_pulses"}, err_cnt, 0);
      if (rd_addr_q.size() == 4 && out_q.size() == 4) begin
        chk({name, "_first_read_after_accept"}, longint'(rd_cyc_q[0] > acc_cyc), 1);
        chk({name, "_first_out_latency"}, longint'(out_cyc_q[0] >= rd_cyc_q[0] + 2), 1);
        for (int k = 0; k < 4; k++) begin
          ea = v.start + 32'(k);
          chk($sformatf("%s_addr%0d", name, k), rd_addr_q[k], ea);
          chk($sformatf("%s_cidx%0d", name, k), rd_idx_q[k], k);
          chk($sformatf("%s_rdcyc%0d", name, k), rd_cyc_q[k], rd_cyc_q[0] + k);
          chk($sformatf("%s_outcyc%0d", name, k), out_cyc_q[k], out_cyc_q[0] + k);
          chk($sformatf("%s_sample%0d", name, k), longint'(out_q[k]), longint'(v.exp_sample));
          chk($sformatf("%s_last%0d", name, k), out_last_q[k], (k == 3));
          chk($sformatf("%s_done%0d", name, k), out_done_q[k], (k == 3));
        end
      end
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    logic [15:0] held;
    logic        held_last;
    int          bad;
    int          k;

    //         start         end           data        coef      err   expected
    vecs[0] = '{32'h00000100, 32'h00000104, 16'sd1000,  16'h8000, 1'b0, 16'sd500};
    vecs[1] = '{32'h00000200, 32'h00000204, -16'sd3,    16'h8000, 1'b0, -16'sd2};
    vecs[2] = '{32'hFFFFFFFE, 32'h00000002, 16'sd7,     16'hFFFF, 1'b0, 16'sd6};
    vecs[3] = '{32'h00000010, 32'h00000016, 16'sd1000,  16'h8000, 1'b1, 16'sd0};
    vecs[4] = '{32'h00000300, 32'h00000304, -16'sd32768,16'hFFFF, 1'b0, -16'sd32768};
    vecs[5] = '{32'h00000400, 32'h00000404, 16'sd32767, 16'h0001, 1'b0, 16'sd0};
    vecs[6] = '{32'h00000500, 32'h00000504, -16'sd1,    16'h0001, 1'b0, -16'sd1};
    vecs[7] = '{32'h00000020, 32'h00000020, 16'sd5,     16'h8000, 1'b1, 16'sd0};
    vecs[8] = '{32'h00000600, 32'h00000604, 16'sd1234,  16'h4000, 1'b0, 16'sd308};
    vecs[9] = '{32'h00000700, 32'h00000704, -16'sd100,  16'h4000, 1'b0, -16'sd25};

    rst = 1'b0;
    i_frame_start = '0;
    i_frame_end   = '0;
    i_valid       = 1'b0;
    i_ready       = 1'b1;

    #12;
    chk_reset_outs("rst0");
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst0_ready_after_release", o_ready, 1);

    for (int i = 0; i < 10; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Backpressure mid-frame: stall after the first sample for 10 cycles.
    clear_mon();
    addr_mode = 1'b1;
    cur_coef  = 16'h8000;
    i_ready   = 1'b1;
    send_desc(32'h00000700, 32'h00000704);
    k = 0;
    while (out_q.size() < 1 && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    i_ready = 1'b0;
    chk("stall_first_out", out_q.size(), 1);
    @(negedge clk);
    held      = o_sample;
    held_last = o_last;
    bad       = 0;
    for (int i = 0; i < 10; i++) begin
      if (!o_valid || o_sample !== held || o_last !== held_last) bad++;
      @(negedge clk);
    end
    chk("stall_stable", bad, 0);
    chk("stall_held_value", held, 16);
    chk("stall_reads_bounded", longint'(rd_addr_q.size() <= 3), 1);
    chk("stall_no_extra_out", out_q.size(), 1);
    @(posedge clk);
    #1;
    i_ready = 1'b1;
    wait_out(4, 30, "stall");
    repeat (2) @(posedge clk);
    #1;
    chk("stall_n_outputs", out_q.size(), 4);
    chk("stall_done_pulses", done_cnt, 1);
    if (out_q.size() == 4) begin
      for (int j = 0; j < 4; j++) begin
        chk($sformatf("stall_sample%0d", j), longint'(out_q[j]), 8 * (j + 1));
        chk($sformatf("stall_last%0d", j), out_last_q[j], (j == 3));
      end
    end

    // Descriptor presented while busy: sticky overflow, frame unaffected.
    chk("ovf_initially_clear", o_ovf, 0);
    clear_mon();
    addr_mode = 1'b0;
    cur_data  = 16'sd1000;
    cur_coef  = 16'h8000;
    i_ready   = 1'b1;
    send_desc(32'h00000800, 32'h00000804);
    i_frame_start = 32'h10;
    i_frame_end   = 32'h16;
    i_valid       = 1'b1;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    chk("ovf_set", o_ovf, 1);
    wait_out(4, 30, "ovf");
    repeat (3) @(posedge clk);
    #1;
    chk("ovf_no_err", err_cnt, 0);
    chk("ovf_n_reads", rd_addr_q.size(), 4);
    chk("ovf_n_outputs", out_q.size(), 4);
    if (out_q.size() == 4) chk("ovf_sample3", longint'(out_q[3]), 500);
    repeat (5) @(posedge clk);
    #1;
    chk("ovf_sticky", o_ovf, 1);

    // Reset in the middle of FETCH with samples held in the buffer.
    clear_mon();
    i_ready = 1'b0;
    send_desc(32'h00000900, 32'h00000904);
    repeat (3) @(posedge clk);
    #2;
    chk("midrst_buffer_busy", o_valid, 1);
    rst = 1'b0;
    #1;
    chk_reset_outs("midrst");
    @(posedge clk);
    #1;
    rst     = 1'b1;
    i_ready = 1'b1;
    clear_mon();
    repeat (8) @(posedge clk);
    #1;
    chk("midrst_no_reads_after", rd_addr_q.size(), 0);
    chk("midrst_no_outputs_after", out_q.size(), 0);
    chk("midrst_ready", o_ready, 1);
    run_vec(vecs[0], "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
